// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings plus the command-issuer FSM states,
// FIFO command word and registered pin-drive bundle.
package alu_pkg;

  typedef enum logic [1:0] {
    OPA_AND = 2'd0,
    OPA_ADD = 2'd1,
    OPA_XOR = 2'd2,
    OPA_OR  = 2'd3
  } operation_a;

  typedef enum logic [1:0] {
    OPB_SUB    = 2'd0,
    OPB_NOT    = 2'd1,
    OPB_SHL    = 2'd2,
    OPB_PASS_B = 2'd3
  } operation_b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } issuer_state_e;

  typedef struct packed {
    logic       mode;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  typedef struct packed {
    logic       en;
    logic       en_a;
    logic       en_b;
    operation_a op_a;
    operation_b op_b;
    logic [7:0] in_a;
    logic [7:0] in_b;
  } alu_drive_t;

  localparam alu_drive_t ALU_DRIVE_IDLE = '0;

  // The opcode port of the unselected mode is parked at its zero encoding.
  function automatic alu_drive_t cmd_to_drive(input alu_cmd_t cmd);
    alu_drive_t d;
    d.en   = 1'b1;
    d.en_a = ~cmd.mode;
    d.en_b = cmd.mode;
    d.op_a = cmd.mode ? OPA_AND : operation_a'(cmd.op);
    d.op_b = cmd.mode ? operation_b'(cmd.op) : OPB_SUB;
    d.in_a = cmd.a;
    d.in_b = cmd.b;
    return d;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU issuer; power-of-two depth so the
// pointers wrap naturally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  alu_cmd_t                 wr_data,
  input  logic                     pop,
  output alu_cmd_t                 rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  alu_cmd_t          r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command front-end: queues commands, drives the ALU pins one command at a
// time, captures the result after ALU_LAT cycles and returns it in order.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_mode,
  input  logic [1:0]             cmd_op,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  output logic                   alu_enable,
  output logic                   alu_enable_a,
  output logic                   alu_enable_b,
  output logic [1:0]             alu_op_a,
  output logic [1:0]             alu_op_b,
  output logic [7:0]             alu_in_a,
  output logic [7:0]             alu_in_b,
  output logic                   alu_irq_clr,
  input  logic [7:0]             alu_out,
  input  logic                   alu_irq,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_data,
  output logic                   res_irq,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned      CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0]    LAT_LOAD = CW'(ALU_LAT - 1);

  issuer_state_e r_state;
  logic [CW-1:0] r_lat_cnt;
  alu_drive_t    r_drv;
  logic          r_irq_clr;
  logic          r_res_valid;
  logic [7:0]    r_res_data;
  logic          r_res_irq;

  alu_cmd_t      w_fifo_wr;
  alu_cmd_t      w_fifo_rd;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_fifo_push;
  logic          w_fifo_pop;

  assign cmd_ready   = rst_n & ~w_fifo_full;
  assign w_fifo_push = cmd_valid & cmd_ready;
  assign w_fifo_wr   = '{mode: cmd_mode, op: cmd_op, a: cmd_a, b: cmd_b};

  // A pop always coincides with loading the drive registers for that command.
  assign w_fifo_pop = ~w_fifo_empty &
                      ((r_state == ST_IDLE) || ((r_state == ST_RESP) && res_ready));

  alu_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (w_fifo_push),
    .wr_data(w_fifo_wr),
    .pop    (w_fifo_pop),
    .rd_data(w_fifo_rd),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= '0;
      r_drv       <= ALU_DRIVE_IDLE;
      r_irq_clr   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_irq   <= 1'b0;
    end else begin
      r_irq_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fifo_pop) begin
            r_drv     <= cmd_to_drive(w_fifo_rd);
            r_lat_cnt <= LAT_LOAD;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_lat_cnt == '0) r_state <= ST_CAPTURE;
          else                 r_lat_cnt <= r_lat_cnt - CW'(1);
        end
        ST_CAPTURE: begin
          r_res_data  <= alu_out;
          r_res_irq   <= alu_irq;
          r_irq_clr   <= alu_irq;
          r_res_valid <= 1'b1;
          r_drv       <= ALU_DRIVE_IDLE;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_fifo_pop) begin
              r_drv     <= cmd_to_drive(w_fifo_rd);
              r_lat_cnt <= LAT_LOAD;
              r_state   <= ST_ISSUE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign alu_enable   = r_drv.en;
  assign alu_enable_a = r_drv.en_a;
  assign alu_enable_b = r_drv.en_b;
  assign alu_op_a     = r_drv.op_a;
  assign alu_op_b     = r_drv.op_b;
  assign alu_in_a     = r_drv.in_a;
  assign alu_in_b     = r_drv.in_b;
  assign alu_irq_clr  = r_irq_clr;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_irq      = r_res_irq;
  assign busy         = (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer: ALU_LAT=1 instance for most scenarios,
// ALU_LAT=3 instance for the latency check.
module tb_alu_cmd_issuer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_mode;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       alu_enable, alu_enable_a, alu_enable_b;
  logic [1:0] alu_op_a, alu_op_b;
  logic [7:0] alu_in_a, alu_in_b, alu_out;
  logic       alu_irq_clr, alu_irq;
  logic       res_valid, res_ready, res_irq, busy;
  logic [7:0] res_data;
  logic [2:0] fifo_count;

  logic       c3_valid, c3_ready, c3_mode;
  logic [1:0] c3_op;
  logic [7:0] c3_a, c3_b;
  logic       en3, ena3, enb3;
  logic [1:0] opa3, opb3;
  logic [7:0] ina3, inb3, out3;
  logic       clr3, irq3;
  logic       rv3, rr3, rirq3, busy3;
  logic [7:0] rd3;
  logic [2:0] cnt3;

  int n_checks;
  int n_fail;

  function automatic logic [7:0] alu_model(input logic en, input logic ea, input logic eb,
                                           input logic [1:0] opa, input logic [1:0] opb,
                                           input logic [7:0] a, input logic [7:0] b);
    if (!en) return 8'h00;
    if (ea) begin
      case (opa)
        2'd0: return a & b;
        2'd1: return a + b;
        2'd2: return a ^ b;
        default: return a | b;
      endcase
    end
    if (eb) begin
      case (opb)
        2'd0: return a - b;
        2'd1: return ~a;
        2'd2: return {a[6:0], 1'b0};
        default: return b;
      endcase
    end
    return 8'h00;
  endfunction

  assign alu_out = alu_model(alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b);
  assign out3    = alu_model(en3, ena3, enb3, opa3, opb3, ina3, inb3);

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_irq_clr(alu_irq_clr), .alu_out(alu_out), .alu_irq(alu_irq),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_irq(res_irq),
    .busy(busy), .fifo_count(fifo_count)
  );

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
    .cmd_mode(c3_mode), .cmd_op(c3_op), .cmd_a(c3_a), .cmd_b(c3_b),
    .alu_enable(en3), .alu_enable_a(ena3), .alu_enable_b(enb3),
    .alu_op_a(opa3), .alu_op_b(opb3), .alu_in_a(ina3), .alu_in_b(inb3),
    .alu_irq_clr(clr3), .alu_out(out3), .alu_irq(irq3),
    .res_valid(rv3), .res_ready(rr3), .res_data(rd3), .res_irq(rirq3),
    .busy(busy3), .fifo_count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready); end
    n_checks++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b} !== 23'h0) begin
      n_fail++; $display("FAIL reset_drives: got en=%b op_a=%h in_a=%h exp all 0", alu_enable, alu_op_a, alu_in_a); end
    n_checks++; if ({res_valid, res_irq, alu_irq_clr, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 0000", {res_valid, res_irq, alu_irq_clr, busy}); end
    n_checks++; if (res_data !== 8'h00) begin n_fail++; $display("FAIL reset_res_data: got %h exp 00", res_data); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d exp 0", fifo_count); end
    n_checks++; if ({en3, rv3, busy3} !== 3'b000) begin n_fail++; $display("FAIL reset_lat3: got %b exp 000", {en3, rv3, busy3}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b exp 1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    res_ready = 1'b1; alu_irq = 1'b0;
    cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_op = 2'b01; cmd_a = 8'h12; cmd_b = 8'h34;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b exp 1", cmd_ready); end
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk); // N+1
    n_checks++; if ({alu_enable, fifo_count, busy} !== {1'b0, 3'd1, 1'b1}) begin
      n_fail++; $display("FAIL single_n1: got en=%b cnt=%0d busy=%b exp 0,1,1", alu_enable, fifo_count, busy); end
    @(posedge clk); #1; @(negedge clk); // N+2 ISSUE
    n_checks++; if ({alu_enable, alu_enable_a, alu_enable_b} !== 3'b110) begin
      n_fail++; $display("FAIL single_issue_en: got %b exp 110", {alu_enable, alu_enable_a, alu_enable_b}); end
    n_checks++; if ({alu_op_a, alu_op_b} !== 4'b0100) begin n_fail++; $display("FAIL single_issue_op: got %b exp 0100", {alu_op_a, alu_op_b}); end
    n_checks++; if ({alu_in_a, alu_in_b} !== 16'h1234) begin n_fail++; $display("FAIL single_issue_in: got %h exp 1234", {alu_in_a, alu_in_b}); end
    n_checks++; if ({res_valid, fifo_count} !== 4'b0000) begin n_fail++; $display("FAIL single_issue_rv_cnt: got %b exp 0000", {res_valid, fifo_count}); end
    @(posedge clk); #1; @(negedge clk); // N+3 CAPTURE
    n_checks++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, res_valid} !== 6'b110010) begin
      n_fail++; $display("FAIL single_capture_hold: got %b exp 110010", {alu_enable, alu_enable_a, alu_enable_b, alu_op_a, res_valid}); end
    @(posedge clk); #1; @(negedge clk); // N+4 RESP
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_rv_n4: got %b exp 1", res_valid); end
    n_checks++; if (res_data !== 8'h46) begin n_fail++; $display("FAIL single_res_data: got %h exp 46", res_data); end
    n_checks++; if ({res_irq, alu_irq_clr} !== 2'b00) begin n_fail++; $display("FAIL single_irq: got %b exp 00", {res_irq, alu_irq_clr}); end
    n_checks++; if ({alu_enable, alu_enable_a, alu_op_a, alu_in_a} !== 12'h0) begin
      n_fail++; $display("FAIL single_resp_drives: got en=%b in_a=%h exp 0", alu_enable, alu_in_a); end
    @(posedge clk); #1; @(negedge clk); // N+5
    n_checks++; if ({res_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_done: got %b exp 00", {res_valid, busy}); end
    @(posedge clk); #1;
  endtask

  task automatic test_irq_clr;
    res_ready = 1'b0; alu_irq = 1'b1;
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_op = 2'b10; cmd_a = 8'h0F; cmd_b = 8'h77;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1; @(negedge clk); // N+2 ISSUE
    n_checks++; if ({alu_enable, alu_enable_a, alu_enable_b} !== 3'b101) begin
      n_fail++; $display("FAIL irq_issue_en: got %b exp 101", {alu_enable, alu_enable_a, alu_enable_b}); end
    n_checks++; if ({alu_op_a, alu_op_b} !== 4'b0010) begin n_fail++; $display("FAIL irq_issue_op: got %b exp 0010", {alu_op_a, alu_op_b}); end
    @(posedge clk); #1;
    @(posedge clk); #1; @(negedge clk); // N+4 first RESP
    n_checks++; if ({res_valid, res_irq, alu_irq_clr} !== 3'b111) begin
      n_fail++; $display("FAIL irq_first_resp: got %b exp 111", {res_valid, res_irq, alu_irq_clr}); end
    n_checks++; if (res_data !== 8'h1E) begin n_fail++; $display("FAIL irq_res_data: got %h exp 1e", res_data); end
    @(posedge clk); #1; @(negedge clk); // N+5 stalled RESP
    n_checks++; if ({res_valid, res_irq, alu_irq_clr} !== 3'b110) begin
      n_fail++; $display("FAIL irq_clr_pulse: got %b exp 110", {res_valid, res_irq, alu_irq_clr}); end
    n_checks++; if (res_data !== 8'h1E) begin n_fail++; $display("FAIL irq_hold_data: got %h exp 1e", res_data); end
    res_ready = 1'b1; alu_irq = 1'b0;
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL irq_released: got %b exp 0", res_valid); end
    @(posedge clk); #1;
    // irq raised only while issuing must not be captured
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_op = 2'b00; cmd_a = 8'h50; cmd_b = 8'h20;
    @(posedge clk); #1; cmd_valid = 1'b0; alu_irq = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if (alu_irq_clr !== 1'b0) begin n_fail++; $display("FAIL irq_issue_noclr: got %b exp 0", alu_irq_clr); end
    @(posedge clk); #1; alu_irq = 1'b0;
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if ({res_valid, res_irq, alu_irq_clr, res_data} !== {3'b100, 8'h30}) begin
      n_fail++; $display("FAIL irq_ignored: got v/irq/clr=%b data=%h exp 100/30", {res_valid, res_irq, alu_irq_clr}, res_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    logic       v_mode [5];
    logic [1:0] v_op   [5];
    logic [7:0] v_a    [5];
    logic [7:0] v_b    [5];
    logic [7:0] v_exp  [5];
    int accepted, got, k;
    bit stop;
    v_mode = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    v_op   = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd3};
    v_a    = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    v_b    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    v_exp  = '{8'h11, 8'h22, 8'h2D, 8'h44, 8'h05};
    res_ready = 1'b0; accepted = 0; stop = 1'b0;
    for (int c = 0; c < 12 && !stop; c++) begin
      k = (accepted < 5) ? accepted : 0;
      cmd_valid = 1'b1; cmd_mode = v_mode[k]; cmd_op = v_op[k]; cmd_a = v_a[k]; cmd_b = v_b[k];
      @(negedge clk);
      if (cmd_ready) accepted++; else stop = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    n_checks++; if (accepted !== 5) begin n_fail++; $display("FAIL fill_accepted: got %0d exp 5", accepted); end
    @(negedge clk);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d exp 4", fifo_count); end
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL fill_stalled_rv: got %b exp 1", res_valid); end
    res_ready = 1'b1; got = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid) begin
        n_checks++;
        if (got >= 5) begin n_fail++; $display("FAIL fill_extra_result: got result %0d exp only 5", got); end
        else if (res_data !== v_exp[got]) begin n_fail++; $display("FAIL fill_order_%0d: got %h exp %h", got, res_data, v_exp[got]); end
        got++;
      end
      @(posedge clk); #1; @(negedge clk);
    end
    n_checks++; if (got !== 5) begin n_fail++; $display("FAIL fill_result_count: got %0d exp 5", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int pushed, got, last, maxcnt;
    res_ready = 1'b1; pushed = 0; got = 0; last = -1; maxcnt = 0;
    for (int c = 0; c < 80; c++) begin
      cmd_valid = (pushed < 8); cmd_mode = 1'b0; cmd_op = 2'd1; cmd_a = 8'(pushed); cmd_b = 8'h80;
      @(negedge clk);
      if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
      if (cmd_valid && cmd_ready) pushed++;
      if (res_valid) begin
        n_checks++; if (res_data !== 8'(8'h80 + got)) begin n_fail++; $display("FAIL b2b_data_%0d: got %h exp %h", got, res_data, 8'(8'h80 + got)); end
        if (got > 0) begin
          n_checks++; if (c - last !== 3) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d exp 3", got, c - last); end
        end
        last = c; got++;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    n_checks++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d exp 8", got); end
    n_checks++; if (maxcnt > 4) begin n_fail++; $display("FAIL b2b_max_fifo: got %0d exp <=4", maxcnt); end
  endtask

  task automatic test_reset_mid;
    bit found, seen;
    res_ready = 1'b0; alu_irq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_op = 2'd1; cmd_a = 8'(k); cmd_b = 8'h01;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = res_valid;
      if (!found) begin @(posedge clk); #1; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_wait_resp: got timeout exp res_valid"); end
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL rstmid_count_resp: got %0d exp 3", fifo_count); end
    res_ready = 1'b1; alu_irq = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if ({alu_enable, fifo_count} !== {1'b1, 3'd2}) begin
      n_fail++; $display("FAIL rstmid_issue: got en=%b cnt=%0d exp 1,2", alu_enable, fifo_count); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_cmd_ready: got %b exp 0", cmd_ready); end
    @(posedge clk); #1; @(negedge clk);
    n_checks++; if ({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b} !== 23'h0) begin
      n_fail++; $display("FAIL rstmid_drives: got en=%b in_a=%h exp 0", alu_enable, alu_in_a); end
    n_checks++; if ({fifo_count, res_valid, alu_irq_clr, busy} !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_state: got cnt=%0d rv=%b clr=%b busy=%b exp 0", fifo_count, res_valid, alu_irq_clr, busy); end
    rst_n = 1'b1; seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1; @(negedge clk);
      seen |= res_valid | alu_irq_clr | alu_enable;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_discarded: got activity %b exp 0", seen); end
    alu_irq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lat3;
    logic exp_en [6];
    logic exp_rv [6];
    exp_en = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_rv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rr3 = 1'b1;
    c3_valid = 1'b1; c3_mode = 1'b0; c3_op = 2'd0; c3_a = 8'hF0; c3_b = 8'h3C;
    @(posedge clk); #1; c3_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++; if ({en3, rv3} !== {exp_en[k], exp_rv[k]}) begin
        n_fail++; $display("FAIL lat3_cycle_N+%0d: got en/rv=%b%b exp %b%b", k + 1, en3, rv3, exp_en[k], exp_rv[k]); end
      if (k == 1) begin
        n_checks++; if ({ena3, enb3, opa3, ina3} !== {2'b10, 2'd0, 8'hF0}) begin
          n_fail++; $display("FAIL lat3_issue_pins: got ea=%b eb=%b opa=%0d ina=%h exp 1,0,0,f0", ena3, enb3, opa3, ina3); end
      end
      if (k == 5) begin
        n_checks++; if ({rd3, rirq3} !== {8'h30, 1'b0}) begin n_fail++; $display("FAIL lat3_result: got %h/%b exp 30/0", rd3, rirq3); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    res_ready = 1'b0; alu_irq = 1'b0;
    c3_valid = 1'b0; c3_mode = 1'b0; c3_op = '0; c3_a = '0; c3_b = '0; rr3 = 1'b0; irq3 = 1'b0;
    test_reset();
    test_single();
    test_irq_clr();
    test_fill();
    test_back_to_back();
    test_reset_mid();
    test_lat3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
